// File: rtl/tt_um_ha_seq_ctrl.sv
// Sequencing controller: performs 4-bit A+B+cin through one time-shared half-adder cell.
// Optional running accumulation is enabled by defining SERIAL_HA_ACCUM_EN.

module ha_cell (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module tt_um_ha_seq_ctrl (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  localparam int unsigned WIDTH = 4;
  localparam int unsigned IDXW  = 2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   wsum_q, wsum_d, sum_q, sum_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               phase_q, phase_d;
  logic               carry_q, carry_d;
  logic               s1_q, s1_d, c1_q, c1_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               start, clear;
  logic [WIDTH-1:0]   a_sel;
  logic               ha_x, ha_y, ha_s, ha_c;
  logic               unused_bits;

  assign start = uio_in[0];
  assign clear = uio_in[1];

`ifdef SERIAL_HA_ACCUM_EN
  assign a_sel       = uio_in[2] ? sum_q : ui_in[WIDTH-1:0];
  assign unused_bits = ^uio_in[7:4];
`else
  assign a_sel       = ui_in[WIDTH-1:0];
  assign unused_bits = ^{uio_in[7:4], uio_in[2]};
`endif

  // Phase 0 adds the operand bits, phase 1 folds in the running carry.
  assign ha_x = phase_q ? s1_q    : a_q[idx_q];
  assign ha_y = phase_q ? carry_q : b_q[idx_q];

  ha_cell u_ha (
    .x_i (ha_x),
    .y_i (ha_y),
    .s_o (ha_s),
    .c_o (ha_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wsum_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      phase_q <= 1'b0;
      carry_q <= 1'b0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wsum_q  <= wsum_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      carry_q <= carry_d;
      s1_q    <= s1_d;
      c1_q    <= c1_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wsum_d  = wsum_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    carry_d = carry_q;
    s1_d    = s1_q;
    c1_d    = c1_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (ena) begin
      if (clear) begin
        state_d = ST_IDLE;
        a_d     = '0;
        b_d     = '0;
        wsum_d  = '0;
        sum_d   = '0;
        idx_d   = '0;
        phase_d = 1'b0;
        carry_d = 1'b0;
        s1_d    = 1'b0;
        c1_d    = 1'b0;
        cout_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              a_d     = a_sel;
              b_d     = ui_in[7:4];
              carry_d = uio_in[3];
              wsum_d  = '0;
              idx_d   = '0;
              phase_d = 1'b0;
              busy_d  = 1'b1;
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (!phase_q) begin
              s1_d    = ha_s;
              c1_d    = ha_c;
              phase_d = 1'b1;
            end else begin
              wsum_d[idx_q] = ha_s;
              carry_d       = c1_q | ha_c;
              phase_d       = 1'b0;
              idx_d         = idx_q + IDXW'(1);
              if (idx_q == LAST_IDX) begin
                sum_d   = wsum_d;
                cout_d  = c1_q | ha_c;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
          ST_DONE: begin
            // A held start must drop before the next launch.
            if (!start) begin
              done_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign uo_out  = {1'b0, done_q, busy_q, cout_q, sum_q};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
